// File: rtl/frame_assembler_pkg.sv
// Shared constants, FSM state type and command-length table for the frame assembler.
package frame_asm_pkg;

  localparam int unsigned CMD_WREQ = 2;
  localparam int unsigned CMD_RREQ = 3;
  localparam int unsigned CMD_RRES = 4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  // Frame length in bytes including the command byte; 0 marks an unknown command.
  function automatic int unsigned cmd_len(input int unsigned cmd);
    case (cmd)
      CMD_WREQ: return 7;
      CMD_RREQ: return 3;
      CMD_RRES: return 5;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/frame_assembler_decode.sv
// Combinational command decode: maps the command field to a frame length and a known flag.
module frame_cmd_decode
  import frame_asm_pkg::*;
#(
  parameter int CMD_W = 3,
  parameter int LEN_W = 4
) (
  input  logic [CMD_W-1:0] cmd_i,
  output logic [LEN_W-1:0] len_o,
  output logic             known_o
);

  int unsigned len_int;

  always_comb begin
    len_int = cmd_len(32'(cmd_i));
    len_o   = LEN_W'(len_int);
    known_o = (len_int != 0);
  end

endmodule

// File: rtl/frame_assembler.sv
// Serial byte to frame assembler with command decode and frame hold until consumed.
// Optional inter-byte timeout enabled by defining FRAME_ASM_TIMEOUT_EN.
module frame_assembler
  import frame_asm_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int MAX_BYTES   = 8,
  parameter int CMD_W       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W-1:0]             in_data,
  input  logic                          in_vld,
  output logic                          in_rdy,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [MAX_BYTES*BYTE_W-1:0]   out_data,
  output logic [$clog2(MAX_BYTES+1)-1:0] out_len,
  output logic [CMD_W-1:0]              out_cmd,
  output logic                          err_vld,
  output logic [1:0]                    err_code
);

  localparam int LEN_W = $clog2(MAX_BYTES+1);

  state_e                             state_q, state_d;
  logic [LEN_W-1:0]                   cnt_q, cnt_d;
  logic [LEN_W-1:0]                   len_q, len_d;
  logic [CMD_W-1:0]                   cmd_q, cmd_d;
  logic [MAX_BYTES-1:0][BYTE_W-1:0]   mem_q, mem_d;
  logic                               err_vld_q, err_vld_d;
  logic [1:0]                         err_code_q, err_code_d;
  logic [LEN_W-1:0]                   dec_len;
  logic                               dec_known;
  logic                               acc;

`ifdef FRAME_ASM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC+1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  frame_cmd_decode #(.CMD_W(CMD_W), .LEN_W(LEN_W)) u_dec (
    .cmd_i   (in_data[CMD_W-1:0]),
    .len_o   (dec_len),
    .known_o (dec_known)
  );

  assign in_rdy   = (state_q != ST_HOLD);
  assign out_vld  = (state_q == ST_HOLD);
  assign acc      = in_vld && in_rdy;
  assign out_len  = len_q;
  assign out_cmd  = cmd_q;
  assign err_vld  = err_vld_q;
  assign err_code = err_code_q;

  // Byte 0 lands in the most significant lane of out_data.
  for (genvar g = 0; g < MAX_BYTES; g++) begin : g_lane
    assign out_data[(MAX_BYTES-1-g)*BYTE_W +: BYTE_W] = mem_q[g];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    mem_d      = mem_q;
    err_vld_d  = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (dec_known) begin
            mem_d[0] = in_data;
            cnt_d    = LEN_W'(1);
            len_d    = dec_len;
            cmd_d    = in_data[CMD_W-1:0];
            state_d  = ST_COLLECT;
          end else begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_UNKNOWN;
          end
        end
      end
      ST_COLLECT: begin
        if (acc) begin
          for (int i = 0; i < MAX_BYTES; i++)
            if (cnt_q == LEN_W'(i)) mem_d[i] = in_data;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) state_d = ST_HOLD;
        end
`ifdef FRAME_ASM_TIMEOUT_EN
        else if (tmr_q == TMR_W'(TIMEOUT_CYC)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          len_d      = '0;
          cmd_d      = '0;
          mem_d      = '0;
          err_vld_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
`endif
      end
      ST_HOLD: begin
        if (out_rdy) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          len_d   = '0;
          cmd_d   = '0;
          mem_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FRAME_ASM_TIMEOUT_EN
  // Counts idle COLLECT cycles; wraps to zero on any accepted byte or on firing.
  always_comb begin
    tmr_d = '0;
    if (state_q == ST_COLLECT && !acc && tmr_q != TMR_W'(TIMEOUT_CYC))
      tmr_d = tmr_q + TMR_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      cmd_q      <= '0;
      mem_q      <= '0;
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef FRAME_ASM_TIMEOUT_EN
      tmr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      mem_q      <= mem_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
`ifdef FRAME_ASM_TIMEOUT_EN
      tmr_q      <= tmr_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Directed plus randomized bench for frame_assembler against a queue-based frame model.
module tb_frame_assembler;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic        out_vld;
  logic        out_rdy;
  logic [63:0] out_data;
  logic [3:0]  out_len;
  logic [2:0]  out_cmd;
  logic        err_vld;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes of the frame being built and a few flags.
  logic [7:0] cur[$];
  int         m_len  = 0;
  bit         m_hold = 0;
  bit         m_err  = 0;
  int         m_code = 0;
  int         m_idle = 0;

  frame_assembler #(.BYTE_W(8), .MAX_BYTES(8), .CMD_W(3), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_len(out_len),
    .out_cmd(out_cmd), .err_vld(err_vld), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic int len_of(input logic [2:0] c);
    case (c)
      3'd2:    return 7;
      3'd3:    return 3;
      3'd4:    return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] exp_data();
    logic [63:0] x = '0;
    for (int i = 0; i < 8; i++)
      x = {x[55:0], (i < cur.size()) ? cur[i] : 8'h00};
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_len = 0; m_hold = 0; m_err = 0; m_code = 0; m_idle = 0;
  endtask

  // One clock: drive, compare against the model, advance the model, step past the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    bit acc;
    int l;
    in_vld = v; in_data = d; out_rdy = r;
    #1;
    chk("out_vld",  64'(out_vld),  64'(m_hold));
    chk("in_rdy",   64'(in_rdy),   64'(!m_hold));
    chk("out_data", out_data,      exp_data());
    chk("out_len",  64'(out_len),  64'(cur.size() > 0 ? m_len : 0));
    chk("out_cmd",  64'(out_cmd),  64'(cur.size() > 0 ? int'(cur[0][2:0]) : 0));
    chk("err_vld",  64'(err_vld),  64'(m_err));
    chk("err_code", 64'(err_code), 64'(m_code));
    acc   = v && !m_hold;
    m_err = 0;
    if (m_hold) begin
      if (r) begin m_hold = 0; cur.delete(); m_len = 0; end
    end else if (acc) begin
      m_idle = 0;
      if (cur.size() == 0) begin
        l = len_of(d[2:0]);
        if (l == 0) begin m_err = 1; m_code = 1; end
        else begin cur.push_back(d); m_len = l; end
      end else begin
        cur.push_back(d);
        if (cur.size() == m_len) m_hold = 1;
      end
    end else if (cur.size() > 0) begin
`ifdef FRAME_ASM_TIMEOUT_EN
      if (m_idle == TMO) begin
        cur.delete(); m_len = 0; m_idle = 0; m_err = 1; m_code = 2;
      end else m_idle++;
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"},  64'(out_vld),  64'd0);
    chk({tag, "_err"},  64'(err_vld),  64'd0);
    chk({tag, "_code"}, 64'(err_code), 64'd0);
    chk({tag, "_len"},  64'(out_len),  64'd0);
    chk({tag, "_cmd"},  64'(out_cmd),  64'd0);
    chk({tag, "_data"}, out_data,      64'd0);
  endtask

  initial begin
    logic [7:0] wreq[7];
    logic [2:0] cmds[8];
    wreq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cmds = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};

    // Reset state
    rst = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_init");
    chk("rst_init_rdy", 64'(in_rdy), 64'd1);
    rst = 1'b1;
    model_reset();

    // Full WREQ frame with consumer always ready
    foreach (wreq[i]) cyc(1'b1, wreq[i], 1'b1);
    chk("wreq_vld",  64'(out_vld), 64'd1);
    chk("wreq_len",  64'(out_len), 64'd7);
    chk("wreq_cmd",  64'(out_cmd), 64'd2);
    chk("wreq_data", out_data,     64'h0211223344556600);
    cyc(1'b0, 8'h00, 1'b1);
    chk("wreq_drop", 64'(out_vld), 64'd0);

    // RREQ held under back-pressure, then a byte offered in the handshake cycle
    cyc(1'b1, 8'h03, 1'b0); cyc(1'b1, 8'hAA, 1'b0); cyc(1'b1, 8'hBB, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h02, 1'b0);
      chk("hold_rdy",  64'(in_rdy), 64'd0);
      chk("hold_data", out_data,    64'h03AABB0000000000);
    end
    cyc(1'b1, 8'h02, 1'b1);
    chk("hs_vld", 64'(out_vld), 64'd0);
    chk("hs_len", 64'(out_len), 64'd0);
    cyc(1'b1, 8'h02, 1'b0);
    chk("hs_next_len", 64'(out_len), 64'd7);
    chk("hs_next_cmd", 64'(out_cmd), 64'd2);
    for (int i = 1; i < 7; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    // Unknown command
    cyc(1'b1, 8'h07, 1'b1);
    chk("unk_err",  64'(err_vld),  64'd1);
    chk("unk_code", 64'(err_code), 64'd1);
    chk("unk_vld",  64'(out_vld),  64'd0);
    chk("unk_rdy",  64'(in_rdy),   64'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("unk_pulse", 64'(err_vld), 64'd0);

    // Stall inside an RRES frame
    cyc(1'b1, 8'h04, 1'b0); cyc(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < TMO + 4; i++) cyc(1'b0, 8'h00, 1'b0);
`ifdef FRAME_ASM_TIMEOUT_EN
    chk("tmo_code", 64'(err_code), 64'd2);
    cyc(1'b1, 8'h03, 1'b0);
    chk("tmo_new_len", 64'(out_len), 64'd3);
    cyc(1'b1, 8'h10, 1'b0); cyc(1'b1, 8'h20, 1'b0);
    chk("tmo_new_vld", 64'(out_vld), 64'd1);
`else
    chk("notmo_code", 64'(err_code), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    chk("notmo_vld", 64'(out_vld), 64'd1);
    chk("notmo_len", 64'(out_len), 64'd5);
`endif
    cyc(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a WREQ frame, then a clean RRES frame
    cyc(1'b1, 8'h02, 1'b0); cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'h02, 1'b0);
    rst = 1'b0; in_vld = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("rres_vld",  64'(out_vld), 64'd1);
    chk("rres_len",  64'(out_len), 64'd5);
    chk("rres_data", out_data,     64'h04C0C1C2C3000000);
    cyc(1'b0, 8'h00, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      d[2:0] = cmds[$urandom_range(0, 7)];
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
